// File: rtl/sort_avl_pkg.sv
// Shared constants and state type for the sort peripheral Avalon-MM initiator.
package sort_avl_pkg;

    localparam logic [1:0] SORT_ADDR_VALUES = 2'd0;
    localparam logic [1:0] SORT_ADDR_RESULT = 2'd1;
    localparam logic [1:0] SORT_ADDR_STATUS = 2'd2;

    localparam int unsigned SORT_NVAL = 5;
    localparam int unsigned SORT_W    = 4;
    localparam int unsigned SORT_VW   = SORT_NVAL * SORT_W;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SETTLE,
        ST_POLL_RD,
        ST_POLL_WT,
        ST_GAP,
        ST_RES_RD,
        ST_RES_WT,
        ST_DONE
    } sortMstState_e;

endpackage

// File: rtl/sort_avl_wait_timer.sv
// Loadable down-counter for the settle and inter-poll idle periods; oExpire is high while the count is zero.
module sort_avl_wait_timer #(
    parameter int unsigned W = 2
) (
    input  logic         iCLK,
    input  logic         iReset_n,
    input  logic         iLoad,
    input  logic [W-1:0] iLoadVal,
    output logic         oExpire
);

    logic [W-1:0] count;

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            count <= '0;
        end else if (iLoad) begin
            count <= iLoadVal;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign oExpire = (count == '0);

endmodule

// File: rtl/sort_avl_master.sv
// Avalon-MM initiator: writes five packed nibbles, polls the status bit, reads back the sorted result.
// Optional poll timeout enabled by defining SORT_MST_TIMEOUT_EN.
module sort_avl_master #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned POLL_GAP      = 2,
    parameter int unsigned POLL_LIMIT    = 1023
) (
    input  logic        iCLK,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic [19:0] iValues,
    output logic        oBusy,
    output logic        oDone,
    output logic [19:0] oResult,
    output logic        oError,
    output logic        oChipsellect_n,
    output logic        oWrite_n,
    output logic        oRead_n,
    output logic [1:0]  oAddress,
    output logic [31:0] oData,
    input  logic [31:0] iData
);

    import sort_avl_pkg::*;

    localparam int unsigned PCW  = $clog2(POLL_LIMIT + 1);
    localparam int unsigned TMAX = (SETTLE_CYCLES > POLL_GAP) ? SETTLE_CYCLES : POLL_GAP;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // The timer is loaded one cycle early (in WRITE / POLL_WT), so the load value is N-1.
    localparam logic [TW-1:0]  SETTLE_LD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0]  GAP_LD    = TW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

`ifdef SORT_MST_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    sortMstState_e state, nextState;

    logic [PCW-1:0] pollCnt;
    logic           pollExhausted;
    logic           tmrLoad;
    logic [TW-1:0]  tmrLoadVal;
    logic           tmrExpire;
    logic           statusDone;
    logic           unusedData;

    assign statusDone    = iData[0];
    assign pollExhausted = TIMEOUT_EN && (pollCnt >= POLL_LAST);
    assign unusedData    = ^iData[31:SORT_VW];

    assign tmrLoad    = (state == ST_WRITE) || (state == ST_POLL_WT);
    assign tmrLoadVal = (state == ST_WRITE) ? SETTLE_LD : GAP_LD;

    sort_avl_wait_timer #(
        .W (TW)
    ) uWaitTimer (
        .iCLK     (iCLK),
        .iReset_n (iReset_n),
        .iLoad    (tmrLoad),
        .iLoadVal (tmrLoadVal),
        .oExpire  (tmrExpire)
    );

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE: begin
                if (iStart) nextState = ST_WRITE;
            end
            ST_WRITE: begin
                nextState = (SETTLE_CYCLES == 0) ? ST_POLL_RD : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmrExpire) nextState = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                nextState = ST_POLL_WT;
            end
            ST_POLL_WT: begin
                if (statusDone) begin
                    nextState = ST_RES_RD;
                end else if (pollExhausted) begin
                    nextState = ST_IDLE;
                end else begin
                    nextState = (POLL_GAP == 0) ? ST_POLL_RD : ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmrExpire) nextState = ST_POLL_RD;
            end
            ST_RES_RD: begin
                nextState = ST_RES_WT;
            end
            ST_RES_WT: begin
                nextState = ST_DONE;
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register, so an async reset releases the bus at once.
    always_comb begin
        oChipsellect_n = 1'b1;
        oWrite_n       = 1'b1;
        oRead_n        = 1'b1;
        oAddress       = SORT_ADDR_VALUES;
        oBusy          = 1'b0;
        oDone          = 1'b0;
        unique case (state)
            ST_IDLE: begin
            end
            ST_WRITE: begin
                oChipsellect_n = 1'b0;
                oWrite_n       = 1'b0;
                oAddress       = SORT_ADDR_VALUES;
                oBusy          = 1'b1;
            end
            ST_POLL_RD: begin
                oChipsellect_n = 1'b0;
                oRead_n        = 1'b0;
                oAddress       = SORT_ADDR_STATUS;
                oBusy          = 1'b1;
            end
            ST_RES_RD: begin
                oChipsellect_n = 1'b0;
                oRead_n        = 1'b0;
                oAddress       = SORT_ADDR_RESULT;
                oBusy          = 1'b1;
            end
            ST_DONE: begin
                oDone = 1'b1;
            end
            default: begin
                oBusy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            oData   <= '0;
            oResult <= '0;
            pollCnt <= '0;
        end else begin
            if (state == ST_IDLE && iStart) begin
                oData   <= {12'd0, iValues};
                pollCnt <= '0;
            end
            if (state == ST_POLL_WT && pollCnt != '1) begin
                pollCnt <= pollCnt + 1'b1;
            end
            if (state == ST_RES_WT) begin
                oResult <= iData[SORT_VW-1:0];
            end
        end
    end

`ifdef SORT_MST_TIMEOUT_EN
    logic errorFlag;

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            errorFlag <= 1'b0;
        end else if (state == ST_IDLE && iStart) begin
            errorFlag <= 1'b0;
        end else if (state == ST_POLL_WT && !statusDone && pollExhausted) begin
            errorFlag <= 1'b1;
        end
    end

    assign oError = errorFlag;
`else
    assign oError = 1'b0;
`endif

endmodule

// File: tb/tb_sort_avl_master.sv
// Directed bench for sort_avl_master with a latency-1 slave model and programmable not-done polls.
module tb_sort_avl_master;

    localparam int S = 4;
    localparam int G = 2;

    logic        iCLK = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iStart = 1'b0;
    logic [19:0] iValues = '0;
    logic        oBusy, oDone, oError;
    logic [19:0] oResult;
    logic        oChipsellect_n, oWrite_n, oRead_n;
    logic [1:0]  oAddress;
    logic [31:0] oData;
    logic [31:0] iData = '0;

    int nVec = 0;
    int nMis = 0;

    int          cyc = 0;
    int          writes = 0, statusReads = 0, resultReads = 0;
    int          strobeErr = 0, spacingErr = 0, doneCount = 0;
    int          lastStatusCyc = 0;
    logic [1:0]  lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    int          bfmNotDone = 0;
    logic [19:0] bfmRes = '0;
    logic [11:0] bfmHi = '0;
    logic        pendValid = 1'b0;
    logic [31:0] pendData = '0;

    sort_avl_master #(
        .SETTLE_CYCLES (S),
        .POLL_GAP      (G),
        .POLL_LIMIT    (8)
    ) dut (
        .iCLK           (iCLK),
        .iReset_n       (iReset_n),
        .iStart         (iStart),
        .iValues        (iValues),
        .oBusy          (oBusy),
        .oDone          (oDone),
        .oResult        (oResult),
        .oError         (oError),
        .oChipsellect_n (oChipsellect_n),
        .oWrite_n       (oWrite_n),
        .oRead_n        (oRead_n),
        .oAddress       (oAddress),
        .oData          (oData),
        .iData          (iData)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        cyc   <= cyc + 1;
        iData <= pendValid ? pendData : 32'h0;
    end

    // Slave model and bus monitor, sampled mid-cycle.
    always @(negedge iCLK) begin
        pendValid = 1'b0;
        if ((oChipsellect_n == 1'b0) != (!oWrite_n || !oRead_n) || (!oWrite_n && !oRead_n))
            strobeErr++;
        if (!oChipsellect_n && !oWrite_n) begin
            writes++;
            lastWrAddr = oAddress;
            lastWrData = oData;
        end
        if (!oChipsellect_n && !oRead_n) begin
            pendValid = 1'b1;
            if (oAddress == 2'd2) begin
                statusReads++;
                // POLL_RD, POLL_WT, G gap cycles, then the next POLL_RD.
                if (lastStatusCyc != 0 && cyc - lastStatusCyc != 2 + G) spacingErr++;
                lastStatusCyc = cyc;
                if (bfmNotDone > 0) begin
                    pendData = 32'hFFFF_FFFE;
                    bfmNotDone--;
                end else begin
                    pendData = 32'hA5A5_A5A5;
                end
            end else begin
                resultReads++;
                pendData = {bfmHi, bfmRes};
            end
        end
        if (oDone) doneCount++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic runOp(input string tag, input logic [19:0] vals, input int nd,
                         input logic [19:0] res, input logic [11:0] hi,
                         input int busyPulses, input bit startOnDone);
        int w0, s0, r0, c0;
        bit seen;
        bfmNotDone    = nd;
        bfmRes        = res;
        bfmHi         = hi;
        lastStatusCyc = 0;
        spacingErr    = 0;
        w0 = writes; s0 = statusReads; r0 = resultReads;
        iValues = vals;
        iStart  = 1'b1;
        c0      = cyc;
        @(negedge iCLK); #1;
        iStart = 1'b0;
        chk({tag, " busy after start"}, oBusy, 1);
        chk({tag, " error cleared"}, oError, 0);
        for (int k = 0; k < busyPulses; k++) begin
            @(negedge iCLK); #1; iStart = 1'b1;
            @(negedge iCLK); #1; iStart = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (oDone) seen = 1'b1;
            else begin
                @(negedge iCLK); #1;
            end
        end
        chk({tag, " done seen"}, seen, 1);
        chk({tag, " latency"}, cyc - (c0 + 1), 5 + S + nd * (2 + G));
        chk({tag, " busy low at done"}, oBusy, 0);
        chk({tag, " result"}, oResult, res);
        chk({tag, " writedata"}, oData, {12'd0, vals});
        if (startOnDone) begin
            iStart = 1'b1;
            @(negedge iCLK); #1;
            iStart = 1'b0;
            chk({tag, " start on done ignored"}, oBusy, 0);
        end
        @(negedge iCLK); #1;
        chk({tag, " write count"}, writes - w0, 1);
        chk({tag, " write addr"}, lastWrAddr, 0);
        chk({tag, " write data"}, lastWrData, {12'd0, vals});
        chk({tag, " status reads"}, statusReads - s0, nd + 1);
        chk({tag, " result reads"}, resultReads - r0, 1);
        chk({tag, " poll spacing"}, spacingErr, 0);
    endtask

    initial begin : main
        int d0, s0;
        bit seen;
        repeat (3) @(negedge iCLK);
        #1;
        chk("reset strobes", {oChipsellect_n, oWrite_n, oRead_n}, 3'b111);
        chk("reset addr", oAddress, 0);
        chk("reset data", oData, 0);
        chk("reset busy/done/err", {oBusy, oDone, oError}, 3'b000);
        chk("reset result", oResult, 0);
        iReset_n = 1'b1;
        repeat (2) @(negedge iCLK);
        #1;

        runOp("t1", 20'h15413, 0, 20'h54311, 12'h000, 0, 1'b0);
        runOp("t2", 20'hABCDE, 3, 20'hEDCBA, 12'h123, 0, 1'b0);
        runOp("t3", 20'h97531, 0, 20'h97531, 12'h000, 3, 1'b1);
        runOp("t6", 20'h00F0F, 1, 20'hFF000, 12'hFFF, 0, 1'b0);

        // Reset during POLL_WT.
        bfmNotDone = 5;
        iValues = 20'h22222;
        iStart  = 1'b1;
        @(negedge iCLK); #1;
        iStart = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge iCLK); #1;
            if (!oRead_n && oAddress == 2'd2) seen = 1'b1;
        end
        chk("t4 reached poll", seen, 1);
        @(negedge iCLK); #1;
        d0 = doneCount;
        iReset_n = 1'b0;
        @(negedge iCLK); #1;
        chk("t4 strobes in reset", {oChipsellect_n, oWrite_n, oRead_n}, 3'b111);
        chk("t4 busy in reset", oBusy, 0);
        iReset_n = 1'b1;
        repeat (20) @(negedge iCLK);
        #1;
        chk("t4 no done", doneCount - d0, 0);
        chk("t4 result cleared", oResult, 0);
        chk("t4 idle", oBusy, 0);
        runOp("t4b", 20'h31415, 0, 20'h11345, 12'hABC, 0, 1'b0);

`ifdef SORT_MST_TIMEOUT_EN
        bfmNotDone = 100000;
        s0 = statusReads;
        d0 = doneCount;
        iValues = 20'h77777;
        iStart  = 1'b1;
        @(negedge iCLK); #1;
        iStart = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge iCLK); #1;
            if (!oBusy) seen = 1'b1;
        end
        chk("t5 timed out", seen, 1);
        repeat (2) @(negedge iCLK);
        #1;
        chk("t5 status reads", statusReads - s0, 8);
        chk("t5 error set", oError, 1);
        chk("t5 no done", doneCount - d0, 0);
        chk("t5 result kept", oResult, 20'h11345);
        runOp("t5b", 20'h12345, 0, 20'h12345, 12'h000, 0, 1'b0);
`else
        s0 = statusReads;
        chk("t5 error tied low", oError, 0);
`endif

        chk("strobe rule", strobeErr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
